// File: rtl/pixel_buffer_ctrl_pkg.sv
// Shared definitions for the sliding-window pixel buffer sequencer:
// FSM state encoding and the address-width helper.
package pixel_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Width needed to address n locations; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_buffer_ctrl_wrap_counter.sv
// Modulo-MAX counter: counts 0..MAX-1 on enable, wraps to 0, clears synchronously.
// wrap flags the terminal count independently of enable.
module pixel_buffer_ctrl_wrap_counter #(
    parameter int unsigned MAX   = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;

    assign wrap = (count_q == WIDTH'(MAX - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pixel_buffer_ctrl.sv
// Sliding-window pixel buffer sequencer: raster pixel intake, circular line-buffer addressing,
// window-valid tracking with one-stage backpressure. PIXEL_BUFFER_CTRL_STATS_EN adds win_count.
module pixel_buffer_ctrl
    import pixel_buffer_ctrl_pkg::*;
#(
    parameter int unsigned FILTER_SIZE = 3,
    parameter int unsigned IMAGE_SIZE  = 8,
    localparam int unsigned AW         = addr_width(IMAGE_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          buf_clk_en,
    output logic [AW-1:0] buf_wr_addr,
    output logic [AW-1:0] buf_rd_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] win_row,
    output logic [AW-1:0] win_col,
    output logic          busy,
`ifdef PIXEL_BUFFER_CTRL_STATS_EN
    output logic [2*AW:0] win_count,
`endif
    output logic          frame_done
);

    localparam int unsigned DEPTH = IMAGE_SIZE - (FILTER_SIZE - 1);
    localparam logic [AW-1:0] EDGE = AW'(FILTER_SIZE - 1);

    state_e        state_q, state_d;
    logic          accept, start_frame, handshake, win_hit, last_pix;
    logic [AW-1:0] ptr, col, row;
    logic          ptr_wrap, col_wrap, row_wrap;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic          frame_done_q, frame_done_d;

    assign start_frame = (state_q == StIdle) & start;
    assign in_ready    = (state_q == StRun) & (~out_valid_q | out_ready);
    assign accept      = in_valid & in_ready;
    assign handshake   = out_valid_q & out_ready;
    assign buf_clk_en  = accept;

    pixel_buffer_ctrl_wrap_counter #(
        .MAX   (DEPTH),
        .WIDTH (AW)
    ) u_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (accept),
        .clear  (1'b0),
        .count  (ptr),
        .wrap   (ptr_wrap)
    );

    pixel_buffer_ctrl_wrap_counter #(
        .MAX   (IMAGE_SIZE),
        .WIDTH (AW)
    ) u_col (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (accept),
        .clear  (start_frame),
        .count  (col),
        .wrap   (col_wrap)
    );

    pixel_buffer_ctrl_wrap_counter #(
        .MAX   (IMAGE_SIZE),
        .WIDTH (AW)
    ) u_row (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (accept & col_wrap),
        .clear  (start_frame),
        .count  (row),
        .wrap   (row_wrap)
    );

    assign buf_wr_addr = ptr;
    // Read leads write by one so the synchronous RAM returns the oldest entry in time;
    // parked at 0 while idle.
    assign buf_rd_addr = (state_q == StIdle) ? '0 : (ptr_wrap ? '0 : ptr + AW'(1));

    assign win_hit  = accept & (row >= EDGE) & (col >= EDGE);
    assign last_pix = accept & col_wrap & row_wrap;

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_pix) state_d = StDrain;
            StDrain: begin
                if (handshake) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (win_hit) begin
            out_valid_d = 1'b1;
            win_row_d   = row - EDGE;
            win_col_d   = col - EDGE;
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            out_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef PIXEL_BUFFER_CTRL_STATS_EN
    logic [2*AW:0] win_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count_q <= '0;
        end else if (start_frame) begin
            win_count_q <= '0;
        end else if (handshake) begin
            win_count_q <= win_count_q + 1'b1;
        end
    end

    assign win_count = win_count_q;
`endif

    assign out_valid  = out_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_buffer_ctrl.sv
// Directed bench for pixel_buffer_ctrl (FILTER_SIZE=3, IMAGE_SIZE=8): reset, full frames,
// backpressure stall, gapped input, mid-frame reset.
module tb_pixel_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, out_ready;
    logic       in_ready, buf_clk_en, out_valid, busy, frame_done;
    logic [2:0] buf_wr_addr, buf_rd_addr, win_row, win_col;
`ifdef PIXEL_BUFFER_CTRL_STATS_EN
    logic [6:0] win_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_buffer_ctrl #(
        .FILTER_SIZE (3),
        .IMAGE_SIZE  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .buf_clk_en  (buf_clk_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_rd_addr (buf_rd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .win_row     (win_row),
        .win_col     (win_col),
        .busy        (busy),
`ifdef PIXEL_BUFFER_CTRL_STATS_EN
        .win_count   (win_count),
`endif
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, "_out_valid"}, 32'(out_valid), 0);
        chk({p, "_in_ready"}, 32'(in_ready), 0);
        chk({p, "_buf_clk_en"}, 32'(buf_clk_en), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_frame_done"}, 32'(frame_done), 0);
        chk({p, "_win_row"}, 32'(win_row), 0);
        chk({p, "_win_col"}, 32'(win_col), 0);
        chk({p, "_wr_addr"}, 32'(buf_wr_addr), 0);
        chk({p, "_rd_addr"}, 32'(buf_rd_addr), 0);
    endtask

    // One frame of 64 pixels; windows must arrive as (r,c) in raster order over 0..5.
    task automatic run_frame(input bit gap, input bit stall, input bit chk_addr,
                             input int abort_at, input string tag);
        int pix = 0, wins = 0, seq_err = 0, clk_err = 0, addr_err = 0, stall_err = 0;
        int first_pix = -1, done_cnt = 0, post = 0, cyc = 0;
        bit stalled = 0, post_stall = 0;
        logic [31:0] wc_at_done = '0;

        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef PIXEL_BUFFER_CTRL_STATS_EN
        chk({tag, "_win_count_clear"}, 32'(win_count), 0);
`endif
        while (post < 3 && cyc < 3000) begin
            in_valid  = (pix < 64) && (gap ? ($urandom_range(0, 1) == 1) : 1'b1);
            out_ready = 1'b1;
            start     = gap && (pix == 40);
            #1;
            if (post_stall) begin
                chk({tag, "_post_stall_valid"}, 32'(out_valid), 1);
                chk({tag, "_post_stall_col"}, 32'(win_col), 1);
                post_stall = 0;
            end
            if (out_valid && first_pix < 0) first_pix = pix;
            if (stall && out_valid && !stalled) begin
                stalled = 1;
                for (int i = 0; i < 5; i++) begin
                    out_ready = 1'b0; in_valid = 1'b1;
                    #1;
                    if (in_ready !== 1'b0 || buf_clk_en !== 1'b0 || out_valid !== 1'b1 ||
                        win_col !== 3'd0 || win_row !== 3'd0) stall_err++;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1; in_valid = 1'b1;
                #1;
                post_stall = 1;
            end
            // With out_ready held high the controller must take every offered pixel in RUN.
            if (buf_clk_en !== in_valid) clk_err++;
            if (chk_addr && pix < 64) begin
                if (buf_wr_addr !== 3'(pix % 6) || buf_rd_addr !== 3'((pix + 1) % 6))
                    addr_err++;
            end
            if (out_valid && out_ready) begin
                if (win_row !== 3'(wins / 6) || win_col !== 3'(wins % 6)) seq_err++;
                wins++;
            end
            if (frame_done) begin
                done_cnt++;
`ifdef PIXEL_BUFFER_CTRL_STATS_EN
                wc_at_done = 32'(win_count);
`endif
            end
            if (buf_clk_en) pix++;
            if (abort_at > 0 && pix == abort_at) begin
                @(posedge clk); #1;
                in_valid = 1'b0; rst_n = 1'b0;
                #1;
                check_reset({tag, "_async"});
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (done_cnt > 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0;
        chk({tag, "_no_timeout"}, 32'(cyc < 3000), 1);
        chk({tag, "_pixels"}, pix, 64);
        chk({tag, "_windows"}, wins, 36);
        chk({tag, "_window_seq"}, seq_err, 0);
        chk({tag, "_clk_en_vs_valid"}, clk_err, 0);
        chk({tag, "_first_window_pix"}, first_pix, 19);
        chk({tag, "_frame_done_count"}, done_cnt, 1);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_in_ready_after"}, 32'(in_ready), 0);
        if (chk_addr) chk({tag, "_addr_wrap"}, addr_err, 0);
        if (stall) chk({tag, "_stall_hold"}, stall_err, 0);
`ifdef PIXEL_BUFFER_CTRL_STATS_EN
        chk({tag, "_win_count_done"}, wc_at_done, 36);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        #3;
        check_reset("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_clk_en", 32'(buf_clk_en), 0);
        chk("idle_wr_addr", 32'(buf_wr_addr), 0);
        chk("idle_busy", 32'(busy), 0);
        in_valid = 1'b0;

        run_frame(1'b0, 1'b0, 1'b1, 0, "b2b");
        run_frame(1'b0, 1'b1, 1'b0, 0, "stall");
        run_frame(1'b1, 1'b0, 1'b0, 0, "gap");
        run_frame(1'b0, 1'b0, 1'b0, 31, "abort");
        run_frame(1'b0, 1'b0, 1'b1, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_buffer_ctrl.md
Name: pixel_buffer_ctrl

Overview:
Sequencer for the sliding-window pixel buffer. It accepts a raster-order pixel stream through a valid/ready handshake and drives the buffer's clock enable and its circular line-buffer write/read addresses. It tracks row and column position and flags when the FILTER_SIZE x FILTER_SIZE window on the buffer output is fully populated. It sits between the image source and the convolution datapath and gives the buffer output a valid/ready handshake with backpressure.

Parameters:
FILTER_SIZE, 3, window edge length in pixels (>=2)
IMAGE_SIZE, 8, image width and height in pixels (square image, > FILTER_SIZE)
DEPTH, IMAGE_SIZE-(FILTER_SIZE-1), line-buffer depth (derived localparam, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a frame when IDLE
in_valid  in  1  source pixel valid
in_ready  out  1  controller accepts pixel this cycle
buf_clk_en  out  1  to buffer clk_en; high exactly on accepted pixels
buf_wr_addr  out  LOG2(IMAGE_SIZE)  line-buffer write address
buf_rd_addr  out  LOG2(IMAGE_SIZE)  line-buffer read address
out_valid  out  1  buffer output holds a complete window
out_ready  in  1  downstream consumes window
win_row  out  LOG2(IMAGE_SIZE)  top-left row of the current window
win_col  out  LOG2(IMAGE_SIZE)  top-left column of the current window
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse when the last window is consumed

Behaviour:
- Reset (async, rst_n low): state IDLE; all counters, addresses, out_valid, frame_done, win_row and win_col are 0; in_ready=0; buf_clk_en=0.
- FSM states IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. start is ignored outside IDLE.
  - RUN -> DRAIN when the pixel at (IMAGE_SIZE-1, IMAGE_SIZE-1) is accepted.
  - DRAIN -> IDLE when the final window handshake completes; frame_done pulses in that same cycle (registered, so visible on the next edge).
- in_ready = (state==RUN) & (~out_valid | out_ready). This gives a single-window backpressure stage: the buffer never shifts while an unconsumed window is held.
- accept = in_valid & in_ready. buf_clk_en = accept (combinational).
- Address pointer ptr in 0..DEPTH-1 advances on accept and wraps DEPTH-1 -> 0.
  - buf_wr_addr = ptr.
  - buf_rd_addr = ptr+1, wrapping DEPTH-1 -> 0. This satisfies the one-cycle synchronous RAM read.
- Position counters col and row give the location of the pixel being accepted.
  - col increments on accept and wraps IMAGE_SIZE-1 -> 0.
  - row increments when col wraps.
  - Both clear on start.
- Window complete when an accepted pixel has row>=FILTER_SIZE-1 and col>=FILTER_SIZE-1.
  - On the next edge: out_valid=1, win_row=row-(FILTER_SIZE-1), win_col=col-(FILTER_SIZE-1).
  - Latency is 1 cycle from accept to out_valid.
- out_valid clears on out_ready unless a new complete window is accepted in the same cycle, in which case it stays high with the updated coordinates.
- Pixels in the first FILTER_SIZE-1 rows, and in columns < FILTER_SIZE-1 of each row, fill the buffer only; they produce no out_valid.
- Windows per frame: (IMAGE_SIZE-FILTER_SIZE+1)^2.
- DRAIN: in_ready=0; hold the last window until out_ready.
- in_valid outside RUN is ignored and no pixel is consumed.
- rst_n asserted mid-frame: immediate abandon to IDLE. Line-buffer contents are stale and are not cleared; the next frame refills them.

Optional Feature:
PIXEL_BUFFER_CTRL_STATS_EN
- Defined: adds output win_count [2*LOG2(IMAGE_SIZE):0].
  - Increments on each out_valid & out_ready handshake.
  - Clears on start and on reset.
  - Holds its value after frame_done until the next start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and the LOG2 address-width helper, reusing the existing definitions include.
- One sub-module is natural: wrap_counter (parameter MAX, ports enable/clear/count/wrap). It is instantiated for ptr, col and row.

Test Plan:
- FILTER_SIZE=3, IMAGE_SIZE=8; start then 64 back-to-back pixels with out_ready=1 -> first out_valid the cycle after pixel index 18 is accepted, with win_row=0 and win_col=0; 36 windows total; frame_done pulses once after window (5,5); busy low afterwards.
- Address wrap, DEPTH=6 -> buf_wr_addr sequence 0..5,0..; buf_rd_addr is always buf_wr_addr+1 mod 6, with buf_rd_addr=0 when buf_wr_addr=5.
- Hold out_ready=0 for 5 cycles while window (0,0) is valid -> in_ready=0, buf_clk_en=0, and out_valid/win_col stay stable; releasing gives window (0,1) on the next accept.
- Randomly gapped in_valid (~50%) -> same 36 window coordinates in raster order; buf_clk_en matches accepts 1:1.
- rst_n low for 1 cycle after pixel 30 -> all outputs return to reset values asynchronously; a new start plus 64 pixels yields 36 correct windows.
- With PIXEL_BUFFER_CTRL_STATS_EN -> win_count=36 at frame_done; a start pulse clears it to 0.
